mem_bus_responder: RTL and testbench

- Memory-side responder for the cache/uncache request bus produced by the data-side cache selector: rd_req/rd_type/rd_addr and wr_req/wr_type/wr_addr/wr_wstrb/wr_data.
- Accepts one request at a time and converts it into word accesses on a synchronous single-port SRAM with 1-cycle read latency.
- Returns read data as a beat stream (ret_valid/ret_last/ret_data).
- Used as the backing store for dcache/uncache bring-up and as the target the verification bench drives the cache path against.

---
 rtl/mem_bus_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the dcache/uncache request bus: serializes read and
// write requests into word accesses on a 1-cycle-latency single-port SRAM.
module mem_bus_responder #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_AW     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     mem_en,
  output logic [3:0]               mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int CW = OW + 1;
  localparam logic [2:0]    TYPE_LINE = 3'b100;
  localparam logic [CW-1:0] LINE_CNT  = CW'(LINE_WORDS);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     beats_q, beats_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       words_q [LINE_WORDS];
  logic [31:0]       words_d [LINE_WORDS];

  logic              rdLine, wrLine;
  logic [MEM_AW-1:0] rdIdx, wrIdx, rdBase, wrBase;
  logic              rdIssue, wrIssue;
  logic              unusedAddrBits;

  // Byte addresses become word indices; line requests drop the in-line offset.
  assign rdIdx  = rd_addr[MEM_AW+1:2];
  assign wrIdx  = wr_addr[MEM_AW+1:2];
  assign rdLine = (rd_type == TYPE_LINE);
  assign wrLine = (wr_type == TYPE_LINE);
  assign rdBase = rdLine ? {rdIdx[MEM_AW-1:OW], {OW{1'b0}}} : rdIdx;
  assign wrBase = wrLine ? {wrIdx[MEM_AW-1:OW], {OW{1'b0}}} : wrIdx;

  assign unusedAddrBits = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                            wr_addr[31:MEM_AW+2], wr_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      base_q  <= '0;
      we_q    <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      base_q  <= base_d;
      we_q    <= we_d;
      words_q <= words_d;
    end
  end

  // Writes win a simultaneous arrival so a dirty-line writeback precedes its refill.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    base_d  = base_q;
    we_d    = we_q;
    words_d = words_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR;
          cnt_d   = '0;
          beats_d = wrLine ? LINE_CNT : ONE_CNT;
          base_d  = wrBase;
          we_d    = wrLine ? 4'hF : wr_wstrb;
          for (int i = 0; i < LINE_WORDS; i++) begin
            words_d[i] = wr_data[32*i +: 32];
          end
        end else if (rd_req) begin
          state_d = RD;
          cnt_d   = '0;
          beats_d = rdLine ? LINE_CNT : ONE_CNT;
          base_d  = rdBase;
        end
      end
      RD: begin
        cnt_d = cnt_q + ONE_CNT;
        if (cnt_q == beats_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WR: begin
        cnt_d = cnt_q + ONE_CNT;
        if (cnt_q == beats_q - ONE_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reads issue on counts 0..N-1 and return on 1..N, one cycle behind the SRAM.
  always_comb begin
    rd_rdy    = 1'b0;
    wr_rdy    = 1'b0;
    rdIssue   = 1'b0;
    wrIssue   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    if (!rst) begin
      wr_rdy    = (state_q == IDLE);
      rd_rdy    = (state_q == IDLE) && !wr_req;
      rdIssue   = (state_q == RD) && (cnt_q < beats_q);
      wrIssue   = (state_q == WR);
      mem_en    = rdIssue || wrIssue;
      ret_valid = (state_q == RD) && (cnt_q != '0);
      ret_last  = ret_valid && (cnt_q == beats_q);
      if (mem_en) begin
        mem_addr = base_q + MEM_AW'(cnt_q);
      end
      if (wrIssue) begin
        mem_we    = we_q;
        mem_wdata = words_q[cnt_q[OW-1:0]];
      end
      if (ret_valid) begin
        ret_data = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus random
// traffic, checked against a word-array reference model of memory contents.
module tb_mem_bus_responder;

  localparam int LW   = 4;
  localparam int AW   = 12;
  localparam int MEMW = 4096;

  logic            clk;
  logic            rst;
  logic            rd_req;
  logic [2:0]      rd_type;
  logic [31:0]     rd_addr;
  logic            rd_rdy;
  logic            ret_valid;
  logic            ret_last;
  logic [31:0]     ret_data;
  logic            wr_req;
  logic [2:0]      wr_type;
  logic [31:0]     wr_addr;
  logic [3:0]      wr_wstrb;
  logic [32*LW-1:0] wr_data;
  logic            wr_rdy;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     memRdata;

  logic [31:0]     sram [MEMW];
  logic [31:0]     refMem [MEMW];
  logic            bdEn;
  logic [AW-1:0]   bdIdx;
  logic [31:0]     bdVal;

  int vectors = 0;
  int misses  = 0;

  mem_bus_responder #(.LINE_WORDS(LW), .MEM_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_type  (rd_type),
    .rd_addr  (rd_addr),
    .rd_rdy   (rd_rdy),
    .ret_valid(ret_valid),
    .ret_last (ret_last),
    .ret_data (ret_data),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(memRdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM with one-cycle read latency; the backdoor port preloads contents.
  always @(posedge clk) begin
    if (bdEn) begin
      sram[bdIdx] = bdVal;
    end else if (mem_en) begin
      if (mem_we == 4'h0) memRdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    bdEn  = 1'b1;
    bdIdx = AW'(idx);
    bdVal = val;
    @(negedge clk);
    bdEn = 1'b0;
    refMem[idx] = val;
  endtask

  function automatic logic [32*LW-1:0] randLine();
    logic [32*LW-1:0] v;
    for (int i = 0; i < LW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic int firstWord(input logic [31:0] addr, input int n);
    int idx;
    idx = int'((addr >> 2) % 32'(MEMW));
    return (n == LW) ? idx - (idx % LW) : idx;
  endfunction

  // Entered in the cycle after a read was accepted; checks every beat and the
  // return to ready.
  task automatic finishRead(input logic [31:0] addr, input logic [2:0] typ);
    int n, base;
    n    = (typ == 3'b100) ? LW : 1;
    base = firstWord(addr, n);
    for (int c = 1; c <= n + 1; c++) begin
      #1;
      checkOutput("rd_mem_en", 32'(mem_en), 32'(c <= n));
      if (c <= n) checkOutput("rd_mem_addr", 32'(mem_addr), 32'((base + c - 1) % MEMW));
      checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
      checkOutput("ret_valid", 32'(ret_valid), 32'(c >= 2));
      checkOutput("ret_last", 32'(ret_last), 32'(c == n + 1));
      if (c >= 2) checkOutput("ret_data", ret_data, refMem[(base + c - 2) % MEMW]);
      checkOutput("rd_rdy_busy", 32'(rd_rdy), 32'h0);
      @(negedge clk);
    end
    #1;
    checkOutput("rd_rdy_after_read", 32'(rd_rdy), 32'h1);
    checkOutput("wr_rdy_after_read", 32'(wr_rdy), 32'h1);
  endtask

  task automatic applyRead(input logic [31:0] addr, input logic [2:0] typ);
    rd_req  = 1'b1;
    rd_type = typ;
    rd_addr = addr;
    #1;
    checkOutput("rd_rdy_idle", 32'(rd_rdy), 32'h1);
    @(negedge clk);
    rd_req  = 1'b0;
    rd_addr = $urandom;
    rd_type = 3'($urandom);
    finishRead(addr, typ);
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [2:0] typ,
                            input logic [3:0] strb, input logic [32*LW-1:0] data);
    int n, base;
    logic [3:0]  expWe;
    logic [31:0] w;
    n     = (typ == 3'b100) ? LW : 1;
    base  = firstWord(addr, n);
    expWe = (n == LW) ? 4'hF : strb;
    wr_req   = 1'b1;
    wr_type  = typ;
    wr_addr  = addr;
    wr_wstrb = strb;
    wr_data  = data;
    #1;
    checkOutput("wr_rdy_idle", 32'(wr_rdy), 32'h1);
    checkOutput("rd_rdy_during_wr_req", 32'(rd_rdy), 32'h0);
    @(negedge clk);
    wr_req   = 1'b0;
    wr_addr  = $urandom;
    wr_type  = 3'($urandom);
    wr_wstrb = 4'($urandom);
    wr_data  = randLine();
    for (int c = 1; c <= n; c++) begin
      #1;
      checkOutput("wr_mem_en", 32'(mem_en), 32'h1);
      checkOutput("wr_mem_addr", 32'(mem_addr), 32'((base + c - 1) % MEMW));
      checkOutput("wr_mem_we", 32'(mem_we), 32'(expWe));
      checkOutput("wr_mem_wdata", mem_wdata, data[32*(c-1) +: 32]);
      checkOutput("wr_rdy_busy", 32'(wr_rdy), 32'h0);
      checkOutput("wr_ret_valid", 32'(ret_valid), 32'h0);
      @(negedge clk);
    end
    #1;
    checkOutput("wr_rdy_after_write", 32'(wr_rdy), 32'h1);
    checkOutput("mem_en_after_write", 32'(mem_en), 32'h0);
    for (int k = 0; k < n; k++) begin
      w = data[32*k +: 32];
      for (int b = 0; b < 4; b++) begin
        if (expWe[b]) refMem[(base + k) % MEMW][8*b +: 8] = w[8*b +: 8];
      end
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [2:0] typ,
                               input logic [3:0] strb, input logic [32*LW-1:0] data);
    if (isWrite) applyWrite(addr, typ, strb, data);
    else         applyRead(addr, typ);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] addr;
    logic [2:0]  typ;
    logic        isLine;
    logic        isWrite;

    rst = 1'b1;  rd_req = 1'b0;  rd_type = 3'b0;  rd_addr = '0;
    wr_req = 1'b0;  wr_type = 3'b0;  wr_addr = '0;  wr_wstrb = '0;  wr_data = '0;
    bdEn = 1'b0;  bdIdx = '0;  bdVal = '0;
    #1;
    checkOutput("reset_rd_rdy", 32'(rd_rdy), 32'h0);
    checkOutput("reset_wr_rdy", 32'(wr_rdy), 32'h0);
    checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_ret_valid", 32'(ret_valid), 32'h0);
    checkOutput("reset_ret_last", 32'(ret_last), 32'h0);
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_rd_rdy", 32'(rd_rdy), 32'h1);
    checkOutput("post_reset_wr_rdy", 32'(wr_rdy), 32'h1);

    $display("[TB] single read");
    preload(4, 32'hDEADBEEF);
    applyRead(32'h0000_0012, 3'b010);

    $display("[TB] line read alignment");
    for (int i = 0; i < 4; i++) preload(16 + i, 32'hA0 + 32'(i));
    applyRead(32'h0000_004C, 3'b100);

    $display("[TB] line write then line read");
    applyWrite(32'h0000_0080, 3'b100, 4'h0, {32'h3, 32'h2, 32'h1, 32'h0});
    applyRead(32'h0000_0080, 3'b100);

    $display("[TB] partial and empty-strobe writes");
    preload(48, 32'h11223344);
    applyWrite(32'h0000_00C0, 3'b000, 4'b0100, {96'h0, 32'hAABBCCDD});
    applyRead(32'h0000_00C0, 3'b000);
    applyWrite(32'h0000_00C4, 3'b010, 4'b0000, randLine());
    applyRead(32'h0000_00C4, 3'b010);

    $display("[TB] simultaneous read and write");
    rd_req = 1'b1;  rd_type = 3'b010;  rd_addr = 32'h0000_0100;
    wr_req = 1'b1;  wr_type = 3'b010;  wr_addr = 32'h0000_0100;
    wr_wstrb = 4'hF;  wr_data = {96'h0, 32'h5A5A1234};
    #1;
    checkOutput("sim_rd_rdy", 32'(rd_rdy), 32'h0);
    checkOutput("sim_wr_rdy", 32'(wr_rdy), 32'h1);
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    checkOutput("sim_wr_mem_we", 32'(mem_we), 32'hF);
    checkOutput("sim_wr_mem_wdata", mem_wdata, 32'h5A5A1234);
    checkOutput("sim_rd_rdy_wr_busy", 32'(rd_rdy), 32'h0);
    refMem[64] = 32'h5A5A1234;
    @(negedge clk);
    #1;
    checkOutput("sim_rd_rdy_after_wr", 32'(rd_rdy), 32'h1);
    @(negedge clk);
    rd_req = 1'b0;
    finishRead(32'h0000_0100, 3'b010);

    $display("[TB] random traffic");
    for (int it = 0; it < 60; it++) begin
      r       = $urandom;
      addr    = {r[31:14], 4'b0, r[9:0]};
      isLine  = 1'($urandom_range(0, 1));
      isWrite = 1'($urandom_range(0, 1));
      if (isLine) typ = 3'b100;
      else if (isWrite) begin
        typ = 3'($urandom);
        if (typ == 3'b100) typ = 3'b000;
      end else typ = 3'($urandom_range(0, 2));
      applyStimulus(isWrite, addr, typ, 4'($urandom), randLine());
    end

    $display("[TB] reset mid-burst");
    rd_req = 1'b1;  rd_type = 3'b100;  rd_addr = 32'h0000_0040;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("burst_beat2_valid", 32'(ret_valid), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("abort_ret_valid", 32'(ret_valid), 32'h0);
    checkOutput("abort_ret_last", 32'(ret_last), 32'h0);
    checkOutput("abort_mem_en", 32'(mem_en), 32'h0);
    checkOutput("abort_rd_rdy", 32'(rd_rdy), 32'h0);
    checkOutput("abort_wr_rdy", 32'(wr_rdy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_idle_rd_rdy", 32'(rd_rdy), 32'h1);
    checkOutput("abort_idle_mem_en", 32'(mem_en), 32'h0);
    checkOutput("abort_idle_ret_valid", 32'(ret_valid), 32'h0);
    applyRead(32'h0000_0012, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
